shift_iter_unit: RTL and testbench

Multi-cycle shift/rotate execution unit in the EX stage of the WISC-style 16-bit pipeline. It sits directly downstream of the ALU B-operand select mux: operand A comes from the register read path, and operand B (the shift amount, low nibble) comes from the B-select output. It replaces a single-cycle barrel shifter with an iterative shifter and holds the pipeline through a stall output until the result is valid.

---
 rtl/shift_iter_unit.sv | 151 +++++++++++++++
 tb/tb_shift_iter_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_iter_unit.sv
//------------------------------------------------------------------------------
// Module   : shift_iter_unit
// Brief    : Iterative 16-bit shift/rotate EX unit; stalls pipeline until done.
//            Optional macro SHIFT_STEP4_EN enables 4-bit steps when cnt >= 4.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_iter_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] InA,
  input  logic [15:0] InB,
  input  logic [1:0]  Op,
  input  logic        flush,
  output logic [15:0] Out,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam logic [1:0] c_OP_ROL = 2'b00;
  localparam logic [1:0] c_OP_SLL = 2'b01;
  localparam logic [1:0] c_OP_ROR = 2'b10;
  localparam logic [1:0] c_OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_val, w_val_nxt;
  logic [15:0] r_out, w_out_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_op, w_op_nxt;
  logic [15:0] w_step1, w_step;
  logic [3:0]  w_dec;
  logic        w_accept;
  logic        w_unused_inb;

  // Upper B-select bits carry no meaning for this unit
  assign w_unused_inb = ^InB[15:4];

  always_comb begin
    w_step1 = r_val;
    case (r_op)
      c_OP_ROL: w_step1 = {r_val[14:0], r_val[15]};
      c_OP_SLL: w_step1 = {r_val[14:0], 1'b0};
      c_OP_ROR: w_step1 = {r_val[0], r_val[15:1]};
      c_OP_SRL: w_step1 = {1'b0, r_val[15:1]};
      default:  w_step1 = r_val;
    endcase
  end

`ifdef SHIFT_STEP4_EN
  logic [15:0] w_step4;

  always_comb begin
    w_step4 = r_val;
    case (r_op)
      c_OP_ROL: w_step4 = {r_val[11:0], r_val[15:12]};
      c_OP_SLL: w_step4 = {r_val[11:0], 4'b0000};
      c_OP_ROR: w_step4 = {r_val[3:0], r_val[15:4]};
      c_OP_SRL: w_step4 = {4'b0000, r_val[15:4]};
      default:  w_step4 = r_val;
    endcase
  end

  always_comb begin
    w_step = w_step1;
    w_dec  = 4'd1;
    if (r_cnt >= 4'd4) begin
      w_step = w_step4;
      w_dec  = 4'd4;
    end
  end
`else
  always_comb begin
    w_step = w_step1;
    w_dec  = 4'd1;
  end
`endif

  assign w_accept = (r_state == S_IDLE) || (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_val_nxt   = r_val;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_out_nxt   = r_out;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_val_nxt = InA;
            w_cnt_nxt = InB[3:0];
            w_op_nxt  = Op;
            if (InB[3:0] == 4'd0) begin
              w_out_nxt   = InA;
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_SHIFT;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_SHIFT: begin
          w_val_nxt = w_step;
          w_cnt_nxt = r_cnt - w_dec;
          // Out is only written on the final step so it never shows partials
          if (r_cnt == w_dec) begin
            w_out_nxt   = w_step;
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_val   <= 16'h0000;
      r_cnt   <= 4'd0;
      r_op    <= 2'b00;
      r_out   <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_val   <= w_val_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign Out   = r_out;
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign stall = (start && w_accept) || (r_state == S_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_shift_iter_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_shift_iter_unit
// Brief    : Self-checking bench for shift_iter_unit against an arithmetic model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_iter_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] InA;
  logic [15:0] InB;
  logic [1:0]  Op;
  logic        flush;
  logic [15:0] Out;
  logic        busy;
  logic        done;
  logic        stall;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_iter_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .InA   (InA),
    .InB   (InB),
    .Op    (Op),
    .flush (flush),
    .Out   (Out),
    .busy  (busy),
    .done  (done),
    .stall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result computed from whole-word arithmetic rather than stepwise
  function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [3:0] n,
                                            input logic [1:0] op);
    logic [31:0] d;
    logic [31:0] t;
    d = {a, a};
    case (op)
      2'b00:   begin t = d << n;            return t[31:16]; end
      2'b01:   begin t = {16'h0000, a} << n; return t[15:0];  end
      2'b10:   begin t = d >> n;            return t[15:0];  end
      default: return a >> n;
    endcase
  endfunction

  function automatic int exp_cycles(input logic [3:0] n);
`ifdef SHIFT_STEP4_EN
    return int'(n) / 4 + int'(n) % 4;
`else
    return int'(n);
`endif
  endfunction

  // Called at a negedge in IDLE/DONE; returns at the negedge after the start edge
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    start = 1'b1; InA = a; InB = b; Op = op;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL start_stall: got %b want 1", stall);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; InA = 16'($urandom); InB = 16'($urandom); Op = 2'($urandom);
  endtask

  task automatic wait_done(input int exp_sh, input logic [15:0] exp_out, input string nm,
                           input bit poke);
    int sh;
    bit seen;
    sh = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      start = 1'b0;
      #1;
      if (done === 1'b1) begin seen = 1'b1; break; end
      n_cmp++;
      if (stall !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s shift_cycle: stall=%b busy=%b want 1/1", nm, stall, busy);
      end
      sh++;
      if (poke && sh == 1) begin
        start = 1'b1; InA = 16'($urandom); InB = 16'($urandom); Op = 2'($urandom);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("FAIL %s timeout: no done within 40 cycles", nm);
    end else begin
      n_cmp++;
      if (sh !== exp_sh) begin
        n_fail++; $display("FAIL %s latency: got %0d shift cycles want %0d", nm, sh, exp_sh);
      end
      n_cmp++;
      if (Out !== exp_out) begin
        n_fail++; $display("FAIL %s out: got %h want %h", nm, Out, exp_out);
      end
      n_cmp++;
      if (stall !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL %s done_flags: stall=%b busy=%b want 0/1", nm, stall, busy);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; flush = 1'b0;
    InA = 16'h1234; InB = 16'h0003; Op = 2'b01;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (Out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset: Out=%h busy=%b done=%b want 0000/0/0", Out, busy, done);
    end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: stall=%b busy=%b done=%b want 0/0/0", stall, busy, done);
    end
  endtask

  task automatic test_directed;
    issue(16'h0001, 16'h0005, 2'b01);
    wait_done(exp_cycles(4'd5), 16'h0020, "sll", 1'b0);
    @(negedge clk);
    issue(16'h0001, 16'h0001, 2'b10);
    wait_done(1, 16'h8000, "ror_wrap", 1'b0);
    issue(16'h8001, 16'hFFF3, 2'b00);
    wait_done(3, 16'h000C, "rol_wrap", 1'b0);
    issue(16'h8001, 16'h0010, 2'b00);
    wait_done(0, 16'h8001, "zero_amt", 1'b0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_flush;
    logic [15:0] prior;
    prior = Out;
    issue(16'hF000, 16'h000F, 2'b11);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || Out !== prior) begin
      n_fail++;
      $display("FAIL flush: busy=%b done=%b Out=%h want 0/0/%h", busy, done, Out, prior);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || Out !== prior) begin
      n_fail++; $display("FAIL flush_nodone: done=%b Out=%h want 0/%h", done, Out, prior);
    end
    issue(16'hF000, 16'h000F, 2'b11);
    wait_done(exp_cycles(4'd15), 16'h0001, "srl_rerun", 1'b0);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    issue(16'h0003, 16'h0002, 2'b01);
    wait_done(2, 16'h000C, "b2b_first", 1'b0);
    issue(16'h0080, 16'h0004, 2'b11);
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done_fall: got %b want 0", done);
    end
    wait_done(exp_cycles(4'd4), 16'h0008, "b2b_second", 1'b1);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_reset_midshift;
    issue(16'hA5A5, 16'h0009, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (Out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: Out=%h busy=%b done=%b stall=%b want 0000/0/0/0",
               Out, busy, done, stall);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    logic [1:0]  op;
    for (int i = 0; i < 40; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      op = 2'($urandom);
      issue(a, b, op);
      wait_done(exp_cycles(b[3:0]), ref_shift(a, b[3:0], op), "random", bit'($urandom));
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    InA = 16'h0000; InB = 16'h0000; Op = 2'b00;
    @(negedge clk);
    test_reset;
    test_directed;
    test_flush;
    test_back_to_back;
    test_reset_midshift;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
